fxp_nth_root_hs: RTL



---
 rtl/fxp_nth_root_hs.sv | 116 +++++++++++
 1 files changed

// File: rtl/fxp_nth_root_hs.sv
// Bit-serial fixed-point k-th root engine with valid/ready handshakes on both sides.
// Build option: define ROOT_EXACT_EARLY_EXIT_EN to stop as soon as the candidate power equals the target.
module fxp_nth_root_hs #(
  parameter int IN_W   = 10,
  parameter int FRAC_W = 10,
  parameter int EXP_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         in_x,
  input  logic [EXP_W-1:0]        in_k,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IN_W+FRAC_W-1:0]  out_data,
  output logic                    out_err
);

  localparam int OUT_W = IN_W + FRAC_W;
  localparam int BW    = $clog2(OUT_W);

  typedef enum logic [1:0] {IDLE, POW, CMP, DONE} state_t;

  state_t             state, state_next;
  logic [OUT_W-1:0]   target, acc, p;
  logic [EXP_W-1:0]   k, cnt;
  logic [BW-1:0]      bit_idx;
  logic               err, sat;

  logic               accept, take, last, exact;
  logic [OUT_W-1:0]   one, cand, acc_cmp, cand_next, mul_next;
  logic [2*OUT_W-1:0] prod, shifted;
  logic               fits;

  assign one     = {{(OUT_W-1){1'b0}}, 1'b1};
  assign accept  = in_valid && (state == IDLE);
  assign cand    = acc | (one << bit_idx);
  assign prod    = {{OUT_W{1'b0}}, p} * {{OUT_W{1'b0}}, cand};
  assign shifted = prod >> FRAC_W;
  assign fits    = (shifted[2*OUT_W-1:OUT_W] == '0);
  assign mul_next = (sat || !fits) ? '1 : shifted[OUT_W-1:0];

  // Truncated powers of tiny candidates collapse to zero, so a zero target must reject every bit.
  assign take      = (p <= target) && (target != '0);
  assign acc_cmp   = take ? cand : acc;
  assign cand_next = acc_cmp | (one << (bit_idx - BW'(1)));
  assign last      = (bit_idx == '0);
`ifdef ROOT_EXACT_EARLY_EXIT_EN
  assign exact = (p == target);
`else
  assign exact = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (in_k <= EXP_W'(1)) ? DONE : POW;
      POW:  if (cnt == k - EXP_W'(1)) state_next = CMP;
      CMP:  state_next = (last || exact) ? DONE : POW;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // p holds the running power of the current candidate; it is primed with cand whenever a bit starts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target  <= '0;
      acc     <= '0;
      p       <= '0;
      k       <= '0;
      cnt     <= '0;
      bit_idx <= '0;
      err     <= 1'b0;
      sat     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          target  <= {in_x, {FRAC_W{1'b0}}};
          k       <= in_k;
          err     <= (in_k == '0);
          acc     <= (in_k == EXP_W'(1)) ? {in_x, {FRAC_W{1'b0}}} : '0;
          bit_idx <= BW'(OUT_W - 1);
          p       <= one << (OUT_W - 1);
          cnt     <= EXP_W'(1);
          sat     <= 1'b0;
        end
        POW: begin
          p   <= mul_next;
          sat <= sat || !fits;
          cnt <= cnt + EXP_W'(1);
        end
        CMP: begin
          acc     <= acc_cmp;
          bit_idx <= bit_idx - BW'(1);
          p       <= cand_next;
          cnt     <= EXP_W'(1);
          sat     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = acc;
  assign out_err   = err;

endmodule
